seq_ripple_adder: RTL and testbench
===================================

# seq_ripple_adder

Multi-cycle, parametrised ripple adder/subtractor. Each cycle it adds one SLICE-bit slice of two WIDTH-bit operands and holds the carry in a register between slices. Operands enter and the result leaves through valid/ready handshakes. It serves datapaths where a full-width combinational ripple chain is too slow for the clock.

## Interface
- WIDTH, 8: operand and result width; must be a multiple of SLICE.
- SLICE, 2: bits added per cycle. NUM_SLICES = WIDTH/SLICE, minimum 1.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- in_valid  in  1  operand request
- in_ready  out  1  block can accept; high only in IDLE
- a  in  WIDTH  augend/minuend
- b  in  WIDTH  addend/subtrahend
- sub  in  1  1 = a-b, 0 = a+b; sampled with operands
- out_valid  out  1  result available; high only in DONE
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result, registered
- cout  out  1  carry out of MSB; for subtract, 1 = no borrow
- ovf  out  1  signed two's-complement overflow; present only with the macro

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready=1.
  - On in_valid: capture a into op_a and (sub ? ~b : b) into op_b; set carry=sub, idx=0, sum=0. Go to RUN.
- RUN, each cycle
  - Add slice idx of op_a, op_b and carry.
  - Write the slice sum to sum[idx*SLICE +: SLICE]; update carry with the slice carry-out.
  - When idx==NUM_SLICES-1: latch cout=carry-out and, if enabled, ovf. Go to DONE. Otherwise idx++.
- DONE
  - out_valid=1; sum, cout and ovf are held stable.
  - On out_ready: go to IDLE. sum, cout and ovf keep their values until the next capture.
- Input signals are ignored outside IDLE; in_ready=0 there.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset values: state=IDLE, in_ready=1 in the first cycle after reset, out_valid=0, sum=0, cout=0, ovf=0, idx=0, carry=0.
- Accept at edge t. Slices are computed at edges t+1 through t+NUM_SLICES. out_valid is high from edge t+NUM_SLICES. Latency is NUM_SLICES cycles.
- The result transfers at the first edge where out_valid and out_ready are both high. The next accept is possible at the following edge, so the minimum period is NUM_SLICES+2 cycles.
- If out_ready is already high when DONE is entered, the result transfers after one cycle of out_valid.
- Reset in any state, including mid-RUN: the next state is IDLE with all reset values. The partial operation is discarded and no out_valid is produced.
- When reset and in_valid are asserted together, reset wins.
- When WIDTH==SLICE: RUN lasts one cycle.

## Configuration
- Macro SEQ_RIPPLE_ADDER_OVF_EN.
- Defined:
  - The ovf port exists.
  - ovf = (carry into MSB) XOR (carry out of MSB), taken from the last slice and latched with cout.
- Undefined:
  - The ovf port and its register are absent.
  - All other behaviour is identical.

## Structure
- Package seq_adder_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default WIDTH and SLICE constants;
  - a function computing NUM_SLICES and the idx width, clog2(NUM_SLICES), minimum 1.
- One sub-module, adder_slice: a combinational SLICE-bit ripple of full adders.
  - Inputs: a, b, cin.
  - Outputs: s, cout, and c_msb_in, the carry into its top bit, used for ovf.

## Test plan
All scenarios use WIDTH=8, SLICE=2 (NUM_SLICES=4) unless stated.
1. a=0x5A, b=0x3C, sub=0 -> sum=0x96, cout=0, ovf=1. out_valid rises exactly 4 edges after accept.
2. a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0. Checks carry propagation across every slice boundary.
3. a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0, ovf=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
4. Hold out_ready=0 for 5 cycles in DONE:
   - out_valid, sum and cout stay stable; in_ready=0; new in_valid is ignored.
   - Raise out_ready: the result transfers in that cycle, and in_ready=1 on the next cycle.
5. Assert reset for one cycle after 2 RUN slices:
   - The next cycle shows IDLE, in_ready=1, out_valid=0, sum=0.
   - A following op 0x01+0x02 gives 0x03.
6. Build without the macro with WIDTH=16, SLICE=4. 0xFFFF+0x0001 -> sum=0x0000, cout=1, latency 4 edges, no ovf port.

Source files
------------

// File: rtl/seq_adder_pkg.sv
// Shared types and sizing helpers for the sequential ripple adder.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_SLICE = 2;

    function automatic int unsigned num_slices(input int unsigned width, input int unsigned slice);
        int unsigned n;
        n = width / slice;
        return (n < 1) ? 1 : n;
    endfunction

    function automatic int unsigned idx_width(input int unsigned width, input int unsigned slice);
        int unsigned w;
        w = $clog2(num_slices(width, slice));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple of full adders; also exposes the carry into
// the top bit so the caller can derive signed overflow.
module adder_slice #(
    parameter int unsigned SLICE = 2
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    always_comb begin : ripple
        logic [SLICE:0] c;
        s    = '0;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < SLICE; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout     = c[SLICE];
        c_msb_in = c[SLICE-1];
    end

endmodule

// File: rtl/seq_ripple_adder.sv
// Multi-cycle adder/subtractor: one SLICE-bit slice per clock, carry held in a
// register between slices. Macro SEQ_RIPPLE_ADDER_OVF_EN adds the ovf port.
module seq_ripple_adder
    import seq_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned SLICE = DEFAULT_SLICE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NUM_SLICES = num_slices(WIDTH, SLICE);
    localparam int unsigned IDX_W      = idx_width(WIDTH, SLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [SLICE-1:0]   sl_s;
    logic               sl_cout;
    logic               sl_c_msb;

    // Subtraction is a + ~b + 1: the inverted b is stored and carry seeded with sub.
    adder_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a        (op_a_q[idx_q*SLICE +: SLICE]),
        .b        (op_b_q[idx_q*SLICE +: SLICE]),
        .cin      (carry_q),
        .s        (sl_s),
        .cout     (sl_cout),
        .c_msb_in (sl_c_msb)
    );

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    carry_d = sub;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*SLICE +: SLICE] = sl_s;
                carry_d = sl_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = sl_cout;
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
                    ovf_d   = sl_c_msb ^ sl_cout;
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
    assign ovf       = ovf_q;
`else
    logic unused_sl_c_msb;
    assign unused_sl_c_msb = sl_c_msb;
`endif

endmodule

// File: tb/tb_seq_ripple_adder.sv
// Self-checking bench: 8/2 instance checked every cycle against an arithmetic
// model, plus a 16/4 instance for wide-slice carry checks.
module tb_seq_ripple_adder;

    localparam int NS8  = 4;
    localparam int NS16 = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, sub, out_valid, out_ready, cout;
    logic [7:0]  a, b, sum;
    logic        ovf;

    logic        w_in_valid, w_in_ready, w_sub, w_out_valid, w_out_ready, w_cout;
    logic [15:0] w_a, w_b, w_sum;
    logic        w_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    seq_ripple_adder #(.WIDTH(8), .SLICE(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    seq_ripple_adder #(.WIDTH(16), .SLICE(4)) dut16 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .a         (w_a),
        .b         (w_b),
        .sub       (w_sub),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .sum       (w_sum),
        .cout      (w_cout)
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
        ,
        .ovf       (w_ovf)
`endif
    );

`ifndef SEQ_RIPPLE_ADDER_OVF_EN
    assign ovf   = 1'b0;
    assign w_ovf = 1'b0;
`endif

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Returns {ovf, cout, sum[15:0]} from plain integer arithmetic.
    function automatic logic [17:0] ref_op(input int w, input logic [15:0] ra,
                                           input logic [15:0] rb, input logic rs);
        longint m, ua, ub, s, sa, sb, sr;
        logic c, o;
        m  = longint'(1) << w;
        ua = longint'(ra) % m;
        ub = longint'(rb) % m;
        if (rs) begin
            s = (ua - ub + m) % m;
            c = (ua >= ub);
        end else begin
            s = (ua + ub) % m;
            c = ((ua + ub) >= m);
        end
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        sr = rs ? sa - sb : sa + sb;
        o  = (sr >= m / 2) || (sr < -(m / 2));
        return {o, c, 16'(s)};
    endfunction

    // Reference model of the 8-bit instance's observable behaviour.
    bit         m_known = 0;
    bit         m_idle, m_valid;
    int         m_cnt;
    logic [7:0] m_sum, p_sum;
    logic       m_cout, m_ovf, p_cout, p_ovf;

    always @(posedge clock) begin
        if (reset) begin
            m_known <= 1; m_idle <= 1; m_valid <= 0; m_cnt <= 0;
            m_sum <= '0; m_cout <= 0; m_ovf <= 0;
        end else if (m_known) begin
            if (m_idle) begin
                if (in_valid) begin
                    logic [17:0] r;
                    r = ref_op(8, {8'h00, a}, {8'h00, b}, sub);
                    p_sum <= r[7:0]; p_cout <= r[16]; p_ovf <= r[17];
                    m_idle <= 0; m_cnt <= NS8;
                end
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end else if (m_cnt == 1) begin
                m_cnt <= 0; m_valid <= 1;
                m_sum <= p_sum; m_cout <= p_cout; m_ovf <= p_ovf;
            end else if (m_valid && out_ready) begin
                m_valid <= 0; m_idle <= 1;
            end
        end
    end

    always @(negedge clock) begin
        if (m_known) begin
            check("in_ready", in_ready, m_idle);
            check("out_valid", out_valid, m_valid);
            if (m_idle || m_valid) begin
                check("sum", sum, m_sum);
                check("cout", cout, m_cout);
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
                check("ovf", ovf, m_ovf);
`endif
            end
        end
    end

    task automatic wait_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                         input int hold, input bit early, input bit poke,
                         output logic [7:0] gs, output logic gc, output logic go, output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin wait_cycle(); guard++; end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        a = ta; b = tb_; sub = ts; in_valid = 1;
        wait_cycle();
        in_valid = 0;
        if (early) out_ready = 1;
        lat = 0;
        while (!out_valid && lat < 20) begin wait_cycle(); lat++; end
        gs = sum; gc = cout; go = ovf;
        if (early) begin
            wait_cycle();
            out_ready = 0;
        end else begin
            for (int i = 0; i < hold; i++) begin
                if (poke) begin
                    in_valid = 1; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
                end
                wait_cycle();
            end
            in_valid = 0;
            out_ready = 1;
            wait_cycle();
            out_ready = 0;
        end
    endtask

    task automatic do_op16(input logic [15:0] ta, input logic [15:0] tb_, input logic ts);
        logic [17:0] r;
        int lat;
        r = ref_op(16, ta, tb_, ts);
        check("w_in_ready", w_in_ready, 1);
        w_a = ta; w_b = tb_; w_sub = ts; w_in_valid = 1;
        wait_cycle();
        w_in_valid = 0;
        lat = 0;
        while (!w_out_valid && lat < 20) begin wait_cycle(); lat++; end
        check("w_latency", lat, NS16);
        check("w_sum", w_sum, r[15:0]);
        check("w_cout", w_cout, r[16]);
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
        check("w_ovf", w_ovf, r[17]);
`endif
        w_out_ready = 1;
        wait_cycle();
        w_out_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] gs;
        logic gc, go;
        int lat;

        reset = 1; in_valid = 0; a = '0; b = '0; sub = 0; out_ready = 0;
        w_in_valid = 0; w_a = '0; w_b = '0; w_sub = 0; w_out_ready = 0;
        wait_cycle(); wait_cycle();
        reset = 0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);

        // Literal pins on the reference model
        check("model_5A+3C", ref_op(8, 16'h5A, 16'h3C, 0), {1'b1, 1'b0, 16'h0096});
        check("model_80-01", ref_op(8, 16'h80, 16'h01, 1), {1'b1, 1'b1, 16'h007F});

        do_op(8'h5A, 8'h3C, 0, 0, 0, 0, gs, gc, go, lat);
        check("t1_sum", gs, 8'h96); check("t1_cout", gc, 0); check("t1_latency", lat, 4);
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
        check("t1_ovf", go, 1);
`endif
        do_op(8'hFF, 8'h01, 0, 1, 0, 0, gs, gc, go, lat);
        check("t2_sum", gs, 8'h00); check("t2_cout", gc, 1);
        do_op(8'h10, 8'h20, 1, 0, 1, 0, gs, gc, go, lat);
        check("t3a_sum", gs, 8'hF0); check("t3a_cout", gc, 0);
        do_op(8'h80, 8'h01, 1, 0, 0, 0, gs, gc, go, lat);
        check("t3b_sum", gs, 8'h7F); check("t3b_cout", gc, 1);
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
        check("t3b_ovf", go, 1);
`endif
        // Back-pressure with ignored requests while DONE
        do_op(8'h37, 8'hC4, 0, 5, 0, 1, gs, gc, go, lat);
        check("t4_sum", gs, 8'hFB);
        check("t4_in_ready_after", in_ready, 1);

        // Reset after two RUN slices
        a = 8'hAB; b = 8'h55; sub = 0; in_valid = 1;
        wait_cycle();
        in_valid = 0;
        wait_cycle(); wait_cycle();
        reset = 1;
        wait_cycle();
        reset = 0;
        check("t5_in_ready", in_ready, 1);
        check("t5_out_valid", out_valid, 0);
        check("t5_sum", sum, 0);
        repeat (6) wait_cycle();
        do_op(8'h01, 8'h02, 0, 0, 0, 0, gs, gc, go, lat);
        check("t5_sum_after", gs, 8'h03);

        // Reset wins over a simultaneous request
        reset = 1; in_valid = 1; a = 8'h11; b = 8'h22;
        wait_cycle();
        reset = 0; in_valid = 0;
        check("rst_vs_valid_in_ready", in_ready, 1);
        repeat (6) wait_cycle();

        for (int i = 0; i < 40; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                  ($urandom % 4) == 0, 1'($urandom), gs, gc, go, lat);
            check("rand_latency", lat, NS8);
        end

        do_op16(16'hFFFF, 16'h0001, 0);
        check("w_t6_sum", w_sum, 16'h0000);
        check("w_t6_cout", w_cout, 1);
        for (int i = 0; i < 8; i++)
            do_op16(16'($urandom), 16'($urandom), 1'($urandom));

        repeat (3) wait_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
